// File: rtl/guess_checker.sv
// Hangman letter-guess engine: holds the secret word, scans one position per
// cycle per guess, and tracks revealed mask, used letters, misses and win/loss.
module guess_checker #(
  parameter int WORD_LEN  = 8,
  parameter int MAX_WRONG = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_game,
  input  logic [5*WORD_LEN-1:0] word_in,
  input  logic [3:0]            word_len,
  input  logic                  guess_valid,
  input  logic [4:0]            guess_letter,
  output logic                  busy,
  output logic [WORD_LEN-1:0]   revealed,
  output logic [2:0]            wrong_count,
  output logic                  result_valid,
  output logic [1:0]            result,
  output logic                  win_game,
  output logic                  lost_game
);
  localparam int              IW   = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [4:0]      WL5  = 5'(WORD_LEN);
  localparam logic [2:0]      MW3  = 3'(MAX_WRONG);
  localparam logic [IW-1:0]   LAST = IW'(WORD_LEN - 1);

  typedef enum logic [2:0] {IDLE, READY, SCAN, RESULT, OVER} state_t;

  state_t                r_state;
  logic [5*WORD_LEN-1:0] r_word;
  logic [4:0]            r_len;
  logic [31:0]           r_used;   // only bits 0..25 are ever set
  logic [4:0]            r_letter;
  logic                  r_hit;
  logic                  r_rep;
  logic [IW-1:0]         r_idx;

  logic [4:0]            w_len;
  logic [WORD_LEN-1:0]   w_mask;
  logic                  w_match;
  logic [2:0]            w_wrong_nx;

  always_comb begin
    w_len = {1'b0, word_len};
    if (word_len == 4'd0 || {1'b0, word_len} > WL5) w_len = WL5;
    // Positions past the word end are shown from the start so they never block a win.
    w_mask = '0;
    for (int i = 0; i < WORD_LEN; i++) w_mask[i] = (5'(i) >= w_len);
  end

  assign w_match    = (r_word[5*r_idx +: 5] == r_letter) && (5'(r_idx) < r_len);
  assign w_wrong_nx = (wrong_count == MW3) ? wrong_count : wrong_count + 3'd1;
  assign busy       = (r_state == SCAN) || (r_state == RESULT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_word       <= '0;
      r_len        <= '0;
      r_used       <= '0;
      r_letter     <= '0;
      r_hit        <= 1'b0;
      r_rep        <= 1'b0;
      r_idx        <= '0;
      revealed     <= '0;
      wrong_count  <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      win_game     <= 1'b0;
      lost_game    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (start_game) begin
        r_word      <= word_in;
        r_len       <= w_len;
        r_used      <= '0;
        r_hit       <= 1'b0;
        r_rep       <= 1'b0;
        r_idx       <= '0;
        revealed    <= w_mask;
        wrong_count <= '0;
        result      <= '0;
        win_game    <= 1'b0;
        lost_game   <= 1'b0;
        r_state     <= READY;
      end else begin
        case (r_state)
          READY: begin
            if (guess_valid && guess_letter <= 5'd25) begin
              r_letter <= guess_letter;
              if (r_used[guess_letter]) begin
                r_rep   <= 1'b1;
                r_state <= RESULT;
              end else begin
                r_used[guess_letter] <= 1'b1;
                r_rep   <= 1'b0;
                r_hit   <= 1'b0;
                r_idx   <= '0;
                r_state <= SCAN;
              end
            end
          end
          SCAN: begin
            if (w_match) begin
              revealed[r_idx] <= 1'b1;
              r_hit           <= 1'b1;
            end
            if (r_idx == LAST) r_state <= RESULT;
            else               r_idx   <= r_idx + 1'b1;
          end
          RESULT: begin
            result_valid <= 1'b1;
            if (r_rep) begin
              result  <= 2'b11;
              r_state <= READY;
            end else if (r_hit) begin
              result <= 2'b01;
              if (&revealed) begin
                win_game <= 1'b1;
                r_state  <= OVER;
              end else begin
                r_state  <= READY;
              end
            end else begin
              result      <= 2'b10;
              wrong_count <= w_wrong_nx;
              if (w_wrong_nx == MW3) begin
                lost_game <= 1'b1;
                r_state   <= OVER;
              end else begin
                r_state   <= READY;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_guess_checker.sv
// Directed bench for guess_checker: word "HANGMAN" (length 7, pad letter Z).
module tb_guess_checker;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_game = 1'b0;
  logic [39:0] word_in;
  logic [3:0]  word_len = 4'd7;
  logic        guess_valid = 1'b0;
  logic [4:0]  guess_letter = 5'd0;
  logic        busy;
  logic [7:0]  revealed;
  logic [2:0]  wrong_count;
  logic        result_valid;
  logic [1:0]  result;
  logic        win_game;
  logic        lost_game;

  int checks = 0;
  int errors = 0;

  // pos7..pos0 = Z N A M G N A H; Z sits past the word end and must never hit.
  assign word_in = {5'd25, 5'd13, 5'd0, 5'd12, 5'd6, 5'd13, 5'd0, 5'd7};

  guess_checker #(.WORD_LEN(8), .MAX_WRONG(6)) dut (
    .clk(clk), .reset(reset), .start_game(start_game), .word_in(word_in),
    .word_len(word_len), .guess_valid(guess_valid), .guess_letter(guess_letter),
    .busy(busy), .revealed(revealed), .wrong_count(wrong_count),
    .result_valid(result_valid), .result(result), .win_game(win_game),
    .lost_game(lost_game)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    start_game = 1'b1;
    tick();
    start_game = 1'b0;
  endtask

  // Issues a guess and waits (bounded) for the result pulse; lat = edges after acceptance.
  // inj >= 0 injects a second guess two cycles into the evaluation.
  task automatic guess(input logic [4:0] l, input int inj, output int lat);
    guess_letter = l;
    guess_valid  = 1'b1;
    tick();
    guess_valid  = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      if (n == 2 && inj >= 0) begin
        chk("busy_at_inject", busy, 1);
        guess_letter = 5'(inj);
        guess_valid  = 1'b1;
      end
      tick();
      guess_valid = 1'b0;
      if (result_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic watch(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      tick();
      if (result_valid) pulses++;
    end
  endtask

  task automatic try_ignored(input logic [4:0] l, output int pulses);
    guess_letter = l;
    guess_valid  = 1'b1;
    tick();
    guess_valid  = 1'b0;
    watch(12, pulses);
  endtask

  initial begin
    int lat;
    int p;
    logic [4:0] misses [4];
    misses[0] = 5'd16; misses[1] = 5'd23; misses[2] = 5'd10; misses[3] = 5'd9;

    // Reset and load
    #3;
    chk("rst_revealed", revealed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    #10 reset = 1'b1;
    tick();
    try_ignored(5'd0, p);
    chk("idle_ignores", p, 0);
    start();
    chk("load_revealed", revealed, 8'h80);
    chk("load_wrong", wrong_count, 0);
    chk("load_win_lost", {win_game, lost_game}, 0);
    chk("load_busy", busy, 0);

    // Hit with duplicates; H injected while busy must be dropped
    guess(5'd0, 7, lat);
    chk("A_lat", lat, 9);
    chk("A_result", result, 2'b01);
    chk("A_revealed", revealed, 8'b1010_0010);
    tick();
    chk("pulse_width", result_valid, 0);
    chk("result_held", result, 2'b01);
    guess(5'd13, -1, lat);
    chk("N_lat", lat, 9);
    chk("N_revealed", revealed, 8'b1110_0110);
    chk("N_wrong", wrong_count, 0);

    // Out-of-range letter
    guess_letter = 5'd30;
    guess_valid  = 1'b1;
    tick();
    guess_valid  = 1'b0;
    chk("bad_letter_busy", busy, 0);
    watch(12, p);
    chk("bad_letter_pulses", p, 0);

    // Win
    guess(5'd7, -1, lat);
    chk("H_lat_not_repeat", lat, 9);
    chk("H_result", result, 2'b01);
    chk("H_revealed", revealed, 8'b1110_0111);
    guess(5'd6, -1, lat);
    chk("G_revealed", revealed, 8'b1110_1111);
    chk("G_no_win", win_game, 0);
    guess(5'd12, -1, lat);
    chk("M_lat", lat, 9);
    chk("M_revealed", revealed, 8'hFF);
    chk("win", win_game, 1);
    chk("win_not_lost", lost_game, 0);
    try_ignored(5'd25, p);
    chk("over_pulses", p, 0);
    chk("win_held", win_game, 1);
    chk("over_wrong", wrong_count, 0);

    // Loss and repeat
    start();
    chk("restart_win", win_game, 0);
    chk("restart_result", result, 0);
    chk("restart_revealed", revealed, 8'h80);
    guess(5'd25, -1, lat);
    chk("Z_lat", lat, 9);
    chk("Z_pad_miss", result, 2'b10);
    chk("Z_wrong", wrong_count, 1);
    guess(5'd25, -1, lat);
    chk("rep_lat", lat, 1);
    chk("rep_result", result, 2'b11);
    chk("rep_wrong", wrong_count, 1);
    foreach (misses[i]) guess(misses[i], -1, lat);
    chk("five_wrong", wrong_count, 5);
    chk("five_not_lost", lost_game, 0);
    guess(5'd21, -1, lat);
    chk("V_lat", lat, 9);
    chk("V_result", result, 2'b10);
    chk("lost_wrong", wrong_count, 6);
    chk("lost", lost_game, 1);
    chk("lost_not_win", win_game, 0);
    try_ignored(5'd0, p);
    chk("lost_pulses", p, 0);
    chk("lost_wrong_held", wrong_count, 6);

    // Abort mid-scan
    start();
    guess_letter = 5'd0;
    guess_valid  = 1'b1;
    tick();
    guess_valid  = 1'b0;
    tick();
    tick();
    start();
    chk("abort_busy", busy, 0);
    chk("abort_rv", result_valid, 0);
    chk("abort_revealed", revealed, 8'h80);
    watch(12, p);
    chk("abort_pulses", p, 0);
    guess(5'd0, -1, lat);
    chk("abort_A_lat", lat, 9);
    chk("abort_A_result", result, 2'b01);
    guess(5'd25, -1, lat);
    chk("pre_rst_wrong", wrong_count, 1);

    // Asynchronous reset mid-scan
    guess_letter = 5'd13;
    guess_valid  = 1'b1;
    tick();
    guess_valid  = 1'b0;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_revealed", revealed, 0);
    chk("arst_wrong", wrong_count, 0);
    chk("arst_result", result, 0);
    chk("arst_busy", busy, 0);
    #1 reset = 1'b1;
    tick();
    try_ignored(5'd13, p);
    chk("arst_idle_pulses", p, 0);
    chk("arst_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end
endmodule
